// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default baud divisor.
// Imported by the serial receiver and its helpers.
package uart_pkg;

   localparam int CLOCKS_PER_BAUD_DEFAULT = 868;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs.
// Flops reset high so an idle-high line never looks like an edge after reset.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] s1;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '1;
         q  <= '1;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/rxuart.sv
// 8N1 serial receiver: mid-bit sampling, one-cycle valid strobe per byte,
// and a single frame_err strobe per bad stop bit or held-low break.
module rxuart
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_BAUD = CLOCKS_PER_BAUD_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int HALF_BAUD = CLOCKS_PER_BAUD / 2;
   localparam int CW        = $clog2(CLOCKS_PER_BAUD);

   localparam logic [CW-1:0] FULL_RELOAD = CW'(CLOCKS_PER_BAUD - 1);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF_BAUD - 1);

   logic          in_s;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    data_n;
   logic          valid_n, ferr_n;
   logic          tick;

   sync2 #(.W(1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (in),
      .q     (in_s)
   );

   assign tick = (cnt == '0);
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shreg     <= shreg_n;
         data      <= data_n;
         valid     <= valid_n;
         frame_err <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = (state == IDLE) ? cnt : cnt - 1'b1;
      idx_n   = idx;
      shreg_n = shreg;
      data_n  = data;
      valid_n = 1'b0;
      ferr_n  = 1'b0;

      unique case (state)
         IDLE: begin
            if (!in_s) begin
               cnt_n   = HALF_RELOAD;
               state_n = START;
            end
         end
         START: begin
            if (tick) begin
               if (!in_s) begin
                  cnt_n   = FULL_RELOAD;
                  idx_n   = '0;
                  state_n = DATA;
               end else begin
                  cnt_n   = '0;
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shreg_n = {in_s, shreg[7:1]};
               cnt_n   = FULL_RELOAD;
               if (idx == 3'd7) begin
                  state_n = STOP;
               end else begin
                  idx_n = idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               cnt_n = '0;
               if (in_s) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = BREAK;
               end
            end
         end
         BREAK: begin
            // hold here until the line recovers so a break flags only once
            cnt_n = '0;
            if (in_s) begin
               state_n = IDLE;
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rxuart.sv
// Self-checking bench for rxuart: a fast-baud instance for the scenario tests
// and a full-rate instance fed by a behavioural transmitter.
module tb_rxuart;

   logic       clk = 1'b0;
   logic       reset;
   logic       in16, in868;
   logic [7:0] data16, data868;
   logic       valid16, ferr16, busy16;
   logic       valid868, ferr868, busy868;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] rx16[256];
   logic [7:0] rx868[256];
   int n16 = 0, n868 = 0;
   int vcyc16 = 0;
   int fe16 = 0, fe868 = 0;
   int both_hi = 0;
   int busy_cnt16 = 0;
   logic [7:0] last16;

   always #5 clk = ~clk;

   rxuart #(.CLOCKS_PER_BAUD(16)) u16 (
      .clk       (clk),
      .reset     (reset),
      .in        (in16),
      .data      (data16),
      .valid     (valid16),
      .frame_err (ferr16),
      .busy      (busy16)
   );

   rxuart #(.CLOCKS_PER_BAUD(868)) u868 (
      .clk       (clk),
      .reset     (reset),
      .in        (in868),
      .data      (data868),
      .valid     (valid868),
      .frame_err (ferr868),
      .busy      (busy868)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid16) begin
         rx16[n16] = data16;
         n16++;
         vcyc16 = cyc;
      end
      if (valid868) begin
         rx868[n868] = data868;
         n868++;
      end
      if (ferr16) fe16++;
      if (ferr868) fe868++;
      if ((valid16 && ferr16) || (valid868 && ferr868)) both_hi++;
      if (busy16) busy_cnt16++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) in868 = v;
      else in16 = v;
   endtask

   // line keeps the stop-bit level on return
   task automatic send_frame(input bit sel, input logic [7:0] b,
                             input logic stop);
      int cpb;
      cpb = sel ? 868 : 16;
      drive(sel, 1'b0);
      step(cpb);
      for (int i = 0; i < 8; i++) begin
         drive(sel, b[i]);
         step(cpb);
      end
      drive(sel, stop);
      step(cpb);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      in16  = 1'b1;
      in868 = 1'b1;
      step(3);
      checks++;
      if (data16 !== 8'h00 || valid16 !== 1'b0 || ferr16 !== 1'b0 ||
          busy16 !== 1'b0) begin
         errors++;
         $display("FAIL reset16: data=%h v=%b fe=%b busy=%b, want 00 0 0 0",
                  data16, valid16, ferr16, busy16);
      end
      checks++;
      if (data868 !== 8'h00 || valid868 !== 1'b0 || ferr868 !== 1'b0 ||
          busy868 !== 1'b0) begin
         errors++;
         $display("FAIL reset868: data=%h v=%b fe=%b busy=%b, want 00 0 0 0",
                  data868, valid868, ferr868, busy868);
      end
      reset = 1'b0;
      step(4);
      last16 = 8'h00;
   endtask

   task automatic test_single;
      int base, f0, t0;
      base = n16;
      f0   = fe16;
      t0   = cyc;
      send_frame(1'b0, 8'h55, 1'b1);
      step(4);
      last16 = 8'h55;
      checks++;
      if (n16 - base !== 1) begin
         errors++;
         $display("FAIL single_count: got %0d valid pulses, want 1", n16 - base);
      end
      checks++;
      if (rx16[base] !== 8'h55) begin
         errors++;
         $display("FAIL single_data: got %h, want 55", rx16[base]);
      end
      checks++;
      if (fe16 !== f0) begin
         errors++;
         $display("FAIL single_ferr: got %0d frame_err, want 0", fe16 - f0);
      end
      checks++;
      if (vcyc16 - t0 < 154 || vcyc16 - t0 > 157) begin
         errors++;
         $display("FAIL single_latency: got %0d cycles, want 154..157",
                  vcyc16 - t0);
      end
      checks++;
      if (busy16 !== 1'b0) begin
         errors++;
         $display("FAIL single_busy: got %b, want 0", busy16);
      end
   endtask

   task automatic test_back_to_back;
      int base;
      base = n16;
      send_frame(1'b0, 8'h00, 1'b1);
      send_frame(1'b0, 8'hFF, 1'b1);
      step(4);
      last16 = 8'hFF;
      checks++;
      if (n16 - base !== 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d, want 2", n16 - base);
      end else begin
         checks++;
         if (rx16[base] !== 8'h00 || rx16[base+1] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_data: got %h %h, want 00 ff",
                     rx16[base], rx16[base+1]);
         end
      end
   endtask

   task automatic test_glitch;
      int base, f0, b0;
      base = n16;
      f0   = fe16;
      b0   = busy_cnt16;
      in16 = 1'b0;
      step(3);
      in16 = 1'b1;
      step(40);
      checks++;
      if (n16 !== base || fe16 !== f0) begin
         errors++;
         $display("FAIL glitch_strobe: valid=%0d ferr=%0d, want 0 0",
                  n16 - base, fe16 - f0);
      end
      checks++;
      if (busy_cnt16 - b0 < 1 || busy_cnt16 - b0 > 8 + 3) begin
         errors++;
         $display("FAIL glitch_busy: busy %0d cycles, want 1..11",
                  busy_cnt16 - b0);
      end
      checks++;
      if (busy16 !== 1'b0) begin
         errors++;
         $display("FAIL glitch_idle: busy=%b, want 0", busy16);
      end
   endtask

   task automatic test_break;
      int base, f0;
      base = n16;
      f0   = fe16;
      send_frame(1'b0, 8'hA5, 1'b0);
      step(40 * 16);
      checks++;
      if (busy16 !== 1'b1) begin
         errors++;
         $display("FAIL break_busy: got %b while line low, want 1", busy16);
      end
      in16 = 1'b1;
      step(5);
      checks++;
      if (busy16 !== 1'b0) begin
         errors++;
         $display("FAIL break_exit: busy=%b after release, want 0", busy16);
      end
      checks++;
      if (fe16 - f0 !== 1 || n16 !== base) begin
         errors++;
         $display("FAIL break_strobes: ferr=%0d valid=%0d, want 1 0",
                  fe16 - f0, n16 - base);
      end
      checks++;
      if (data16 !== last16) begin
         errors++;
         $display("FAIL break_data: got %h, want %h", data16, last16);
      end
      send_frame(1'b0, 8'h5A, 1'b1);
      step(4);
      last16 = 8'h5A;
      checks++;
      if (n16 - base !== 1 || data16 !== 8'h5A) begin
         errors++;
         $display("FAIL break_recover: count=%0d data=%h, want 1 5a",
                  n16 - base, data16);
      end
   endtask

   task automatic test_reset_mid;
      int base, f0;
      logic [7:0] b;
      b    = 8'h3C;
      base = n16;
      f0   = fe16;
      in16 = 1'b0;
      step(16);
      for (int i = 0; i < 4; i++) begin
         in16 = b[i];
         step(16);
      end
      in16  = b[4];
      step(8);
      reset = 1'b1;
      step(1);
      checks++;
      if (data16 !== 8'h00 || valid16 !== 1'b0 || ferr16 !== 1'b0 ||
          busy16 !== 1'b0) begin
         errors++;
         $display("FAIL midreset_out: data=%h v=%b fe=%b busy=%b, want 00 0 0 0",
                  data16, valid16, ferr16, busy16);
      end
      in16 = 1'b1;
      step(3);
      reset = 1'b0;
      step(5);
      last16 = 8'h00;
      send_frame(1'b0, 8'hC3, 1'b1);
      step(4);
      last16 = 8'hC3;
      checks++;
      if (n16 - base !== 1 || fe16 !== f0) begin
         errors++;
         $display("FAIL midreset_strobes: valid=%0d ferr=%0d, want 1 0",
                  n16 - base, fe16 - f0);
      end
      checks++;
      if (data16 !== 8'hC3) begin
         errors++;
         $display("FAIL midreset_data: got %h, want c3", data16);
      end
   endtask

   task automatic test_random;
      logic [7:0] exp[$];
      logic [7:0] b;
      int base, f0, nbad, gap;
      bit bad;
      base = n16;
      f0   = fe16;
      nbad = 0;
      for (int k = 0; k < 20; k++) begin
         b   = 8'($urandom);
         bad = ($urandom_range(0, 4) == 0);
         send_frame(1'b0, b, !bad);
         if (bad) begin
            nbad++;
            in16 = 1'b1;
            gap  = 4 + $urandom_range(0, 10);
         end else begin
            exp.push_back(b);
            last16 = b;
            gap = $urandom_range(0, 20);
         end
         if (gap > 0) step(gap);
      end
      step(10);
      checks++;
      if (n16 - base !== exp.size() || fe16 - f0 !== nbad) begin
         errors++;
         $display("FAIL random_count: valid=%0d ferr=%0d, want %0d %0d",
                  n16 - base, fe16 - f0, exp.size(), nbad);
      end else begin
         for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (rx16[base+i] !== exp[i]) begin
               errors++;
               $display("FAIL random_data[%0d]: got %h, want %h",
                        i, rx16[base+i], exp[i]);
            end
         end
      end
      checks++;
      if (data16 !== last16) begin
         errors++;
         $display("FAIL random_hold: data=%h, want %h", data16, last16);
      end
   endtask

   task automatic test_loopback;
      int base, f0;
      base = n868;
      f0   = fe868;
      send_frame(1'b1, 8'h48, 1'b1);
      send_frame(1'b1, 8'h69, 1'b1);
      step(10);
      checks++;
      if (n868 - base !== 2 || fe868 !== f0) begin
         errors++;
         $display("FAIL loop_count: valid=%0d ferr=%0d, want 2 0",
                  n868 - base, fe868 - f0);
      end else begin
         checks++;
         if (rx868[base] !== 8'h48 || rx868[base+1] !== 8'h69) begin
            errors++;
            $display("FAIL loop_data: got %h %h, want 48 69",
                     rx868[base], rx868[base+1]);
         end
      end
   endtask

   task automatic test_exclusive;
      checks++;
      if (both_hi !== 0) begin
         errors++;
         $display("FAIL strobe_overlap: %0d cycles with both, want 0", both_hi);
      end
   endtask

   initial begin
      reset = 1'b1;
      in16  = 1'b1;
      in868 = 1'b1;
      @(posedge clk);
      #1;
      test_reset;
      test_single;
      test_back_to_back;
      test_glitch;
      test_break;
      test_reset_mid;
      test_random;
      test_loopback;
      test_exclusive;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
